// File: rtl/rr_arb_oh_pkg.sv
// Shared definitions for the round-robin arbiter: lock state and one-hot encoding helper.
package rr_arb_oh_pkg;

  localparam int unsigned MaxWidth    = 64;
  localparam int unsigned MaxIdxWidth = 6;

  typedef enum logic {
    Unlocked = 1'b0,
    Locked   = 1'b1
  } lock_e;

  // Binary index of a one-hot (or zero) vector; zero input yields 0.
  function automatic logic [MaxIdxWidth-1:0] oh_to_idx(input logic [MaxWidth-1:0] oh);
    logic [MaxIdxWidth-1:0] idx;
    idx = '0;
    for (int i = 0; i < MaxWidth; i++) begin
      if (oh[i]) idx = idx | MaxIdxWidth'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb_oh_mux.sv
// One-hot select mux; output is zero when the select is zero.
module rr_arb_oh_mux #(
  parameter int unsigned InputWidth = 8,
  parameter int unsigned DataWidth  = 8
) (
  input  logic [InputWidth-1:0][DataWidth-1:0] data_i,
  input  logic [InputWidth-1:0]                sel_i,
  output logic [DataWidth-1:0]                 data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < InputWidth; i++) begin
      data_o = data_o | (data_i[i] & {DataWidth{sel_i[i]}});
    end
  end

endmodule

// File: rtl/rr_arb_oh.sv
// Round-robin valid/ready arbiter with grant lock during consumer stall.
module rr_arb_oh
  import rr_arb_oh_pkg::*;
#(
  parameter int unsigned InputWidth = 8,
  parameter int unsigned DataWidth  = 8,
  localparam int unsigned IdxWidth  = $clog2(InputWidth)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [InputWidth-1:0]                req_valid_i,
  input  logic [InputWidth-1:0][DataWidth-1:0] req_data_i,
  output logic [InputWidth-1:0]                req_ready_o,
  output logic                                 out_valid_o,
  output logic [DataWidth-1:0]                 out_data_o,
  input  logic                                 out_ready_i,
  output logic [InputWidth-1:0]                gnt_oh_o,
  output logic [IdxWidth-1:0]                  gnt_idx_o
);

  lock_e                 lock_q;
  logic [InputWidth-1:0] prio_q;
  logic [InputWidth-1:0] lock_gnt_q;

  logic [InputWidth-1:0] masked_req;
  logic [InputWidth-1:0] arb_gnt;
  logic [InputWidth-1:0] gnt;
  logic                  handshake;

  // Lowest set bit at or above the pointer, else lowest set bit overall.
  always_comb begin
    masked_req = req_valid_i & ~(prio_q - InputWidth'(1));
    if (|masked_req) begin
      arb_gnt = masked_req & (~masked_req + InputWidth'(1));
    end else begin
      arb_gnt = req_valid_i & (~req_valid_i + InputWidth'(1));
    end
  end

  assign gnt         = (lock_q == Locked) ? lock_gnt_q : arb_gnt;
  assign out_valid_o = |(gnt & req_valid_i);
  assign handshake   = out_valid_o & out_ready_i;
  assign req_ready_o = gnt & {InputWidth{out_ready_i}};
  assign gnt_oh_o    = gnt;
  assign gnt_idx_o   = IdxWidth'(oh_to_idx(MaxWidth'(gnt)));

  rr_arb_oh_mux #(
    .InputWidth (InputWidth),
    .DataWidth  (DataWidth)
  ) u_mux (
    .data_i (req_data_i),
    .sel_i  (gnt),
    .data_o (out_data_o)
  );

  // Lock FSM and priority pointer; pointer moves to the slot after each winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= Unlocked;
      prio_q     <= InputWidth'(1);
      lock_gnt_q <= '0;
    end else begin
      if (handshake) prio_q <= {gnt[InputWidth-2:0], gnt[InputWidth-1]};
      case (lock_q)
        Unlocked: begin
          if (out_valid_o && !out_ready_i) begin
            lock_q     <= Locked;
            lock_gnt_q <= gnt;
          end
        end
        Locked: begin
          if (handshake) lock_q <= Unlocked;
        end
        default: lock_q <= Unlocked;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_oh_o));
  a_prio_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot(prio_q));
  a_gnt_stable:  assert property (@(posedge clk) disable iff (!rst_n)
                                  (out_valid_o && !out_ready_i) |=> $stable(gnt_oh_o));
`endif

endmodule

// File: tb/tb_rr_arb_oh.sv
// Directed bench for rr_arb_oh: rotation, lock, wrap-around, late arrival, async reset.
module tb_rr_arb_oh;

  logic            clk;
  logic            rst_n;
  logic [7:0]      req_valid;
  logic [7:0][7:0] req_data;
  logic [7:0]      req_ready;
  logic            out_valid;
  logic [7:0]      out_data;
  logic            out_ready;
  logic [7:0]      gnt_oh;
  logic [2:0]      gnt_idx;

  int n_checks = 0;
  int n_errors = 0;

  rr_arb_oh #(
    .InputWidth (8),
    .DataWidth  (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ready_i (out_ready),
    .gnt_oh_o    (gnt_oh),
    .gnt_idx_o   (gnt_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check all outputs against a hand-computed expected grant.
  task automatic check_out(input string tag, input logic [7:0] exp_gnt);
    logic [2:0] exp_idx;
    logic [7:0] exp_data;
    exp_idx  = '0;
    exp_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (exp_gnt[i]) begin
        exp_idx  = 3'(i);
        exp_data = 8'hA0 + 8'(i);
      end
    end
    check({tag, "_gnt"},   32'(gnt_oh),    32'(exp_gnt));
    check({tag, "_idx"},   32'(gnt_idx),   32'(exp_idx));
    check({tag, "_valid"}, 32'(out_valid), 32'(|(exp_gnt & req_valid)));
    check({tag, "_data"},  32'(out_data),  32'(exp_data));
    check({tag, "_ready"}, 32'(req_ready), 32'(exp_gnt & {8{out_ready}}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp;
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) req_data[i] = 8'hA0 + 8'(i);
    repeat (2) tick();
    rst_n = 1'b1;

    // Idle after reset
    @(negedge clk);
    check_out("idle", 8'h00);
    tick();

    // All valid, consumer always ready: rotation 0..7,0
    req_valid = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp = 8'h01 << (i % 8);
      @(negedge clk);
      check_out("rot", exp);
      tick();
    end

    // Wrap-around: grant 7, then 0 wins over 7
    req_valid = 8'h80;
    @(negedge clk);
    check_out("wrap7", 8'h80);
    tick();
    req_valid = 8'h81;
    @(negedge clk);
    check_out("wrap0", 8'h01);
    tick();

    // Bring pointer back to bit 0
    req_valid = 8'h80;
    @(negedge clk);
    check_out("prep", 8'h80);
    tick();

    // Lock on requester 2 for 3 stall cycles, then handshake
    req_valid = 8'h24;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_out("lock_stall", 8'h04);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_out("lock_hs", 8'h04);
    tick();
    @(negedge clk);
    check_out("lock_next", 8'h20);
    tick();

    // Late arrival: requester 3 locked, requester 1 raises valid
    req_valid = 8'h08;
    out_ready = 1'b0;
    @(negedge clk);
    check_out("late_lock", 8'h08);
    tick();
    req_valid = 8'h0A;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_out("late_hold", 8'h08);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_out("late_hs", 8'h08);
    tick();
    @(negedge clk);
    check_out("late_next", 8'h02);
    tick();

    // Lock on requester 5, then asynchronous reset mid-cycle
    req_valid = 8'h20;
    out_ready = 1'b0;
    @(negedge clk);
    check_out("rst_lock", 8'h20);
    tick();
    req_valid = 8'h21;
    @(negedge clk);
    check_out("rst_locked", 8'h20);
    #2;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    check_out("rst_async", 8'h01);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_out("rst_release", 8'h01);
    tick();

    // Single requester granted every cycle
    req_valid = 8'h10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_out("single", 8'h10);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
